// File: rtl/counter_timestamp_capture.sv
// Captures the live upstream count on rising edges of an asynchronous event line
// and buffers the timestamps in a small first-word-fall-through FIFO.
module counter_timestamp_capture #(
   parameter int unsigned COUNTER_WIDTH = 64,
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned SYNC_STAGES   = 2
) (
   input  logic                          clock0,
   input  logic                          reset,
   input  logic [COUNTER_WIDTH-1:0]      counter_value,
   input  logic                          event_in,
   input  logic                          capture_enable,
   output logic                          ts_valid,
   input  logic                          ts_ready,
   output logic [COUNTER_WIDTH-1:0]      ts_data,
   output logic [$clog2(FIFO_DEPTH):0]   ts_count,
   output logic                          overflow,
   input  logic                          overflow_clear,
   output logic [15:0]                   drop_count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [SYNC_STAGES-1:0]   sync_q, sync_d;
   logic                     hist_q, hist_d;
   logic                     sync_out, rise;

   logic [COUNTER_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]            count_q, count_d;
   logic                     overflow_q, overflow_d;
   logic [15:0]              drop_q, drop_d;

   logic full, pop, push_req, push, drop;

   // Synchronizer and history start high so a line already high at reset release is not an edge.
   assign sync_out = sync_q[SYNC_STAGES-1];
   assign rise     = sync_out & ~hist_q;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], event_in};
      hist_d = sync_out;
   end

   assign full     = (count_q == CW'(FIFO_DEPTH));
   assign ts_valid = (count_q != '0);
   assign pop      = ts_valid & ts_ready;
   assign push_req = rise & capture_enable;
   assign push     = push_req & (~full | pop);
   assign drop     = push_req & full & ~pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // A drop in the same cycle as a clear wins, restarting the tally at one.
   always_comb begin
      overflow_d = overflow_q;
      drop_d     = drop_q;
      if (drop) begin
         overflow_d = 1'b1;
         if (overflow_clear)        drop_d = 16'd1;
         else if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end else if (overflow_clear) begin
         overflow_d = 1'b0;
         drop_d     = '0;
      end
   end

   always_ff @(posedge clock0 or negedge reset) begin
      if (!reset) begin
         sync_q     <= '1;
         hist_q     <= 1'b1;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         sync_q     <= sync_d;
         hist_q     <= hist_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
      end
   end

   // When full, a push with a coincident pop reuses the slot being vacated.
   always_ff @(posedge clock0) begin
      if (push) mem_q[wr_ptr_q] <= counter_value;
   end

   assign ts_data    = ts_valid ? mem_q[rd_ptr_q] : '0;
   assign ts_count   = count_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_counter_timestamp_capture.sv
// Directed bench for counter_timestamp_capture: latency, fill/overflow, push+pop at full,
// clear-versus-drop, enable gating and asynchronous reset.
module tb_counter_timestamp_capture;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] counter_value = '0;
   logic        event_in = 1'b0;
   logic        capture_enable = 1'b1;
   logic        ts_valid;
   logic        ts_ready = 1'b0;
   logic [63:0] ts_data;
   logic [2:0]  ts_count;
   logic        overflow;
   logic        overflow_clear = 1'b0;
   logic [15:0] drop_count;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   logic [63:0] q [$];
   logic [63:0] e;

   counter_timestamp_capture #(
      .COUNTER_WIDTH (64),
      .FIFO_DEPTH    (4),
      .SYNC_STAGES   (2)
   ) dut (
      .clock0         (clk),
      .reset          (rst_n),
      .counter_value  (counter_value),
      .event_in       (event_in),
      .capture_enable (capture_enable),
      .ts_valid       (ts_valid),
      .ts_ready       (ts_ready),
      .ts_data        (ts_data),
      .ts_count       (ts_count),
      .overflow       (overflow),
      .overflow_clear (overflow_clear),
      .drop_count     (drop_count)
   );

   always #5 clk = ~clk;

   // Upstream counter advances on the falling edge, stable at each posedge.
   always @(negedge clk) counter_value <= counter_value + 64'd1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // One-sample event pulse; exp is the count present at the push posedge (k+2).
   task automatic fire(output logic [63:0] exp, input bit rdy_at_push, input bit clr_at_push);
      step();
      event_in = 1'b1;
      exp = counter_value + 64'd2;
      step();
      event_in = 1'b0;
      step();
      ts_ready = rdy_at_push;
      overflow_clear = clr_at_push;
      step();
      ts_ready = 1'b0;
      overflow_clear = 1'b0;
   endtask

   task automatic pop_expect(input string tag, input logic [63:0] exp);
      check({tag, "_valid"}, 64'(ts_valid), 64'd1);
      check({tag, "_data"}, ts_data, exp);
      ts_ready = 1'b1;
      step();
      ts_ready = 1'b0;
   endtask

   initial begin
      // Reset held with event_in high: release must not look like an edge.
      event_in = 1'b1;
      repeat (3) step();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         check("idle_valid", 64'(ts_valid), 64'd0);
         check("idle_count", 64'(ts_count), 64'd0);
      end
      check("idle_ovf", 64'(overflow), 64'd0);
      check("idle_drop", 64'(drop_count), 64'd0);
      check("idle_data", ts_data, 64'd0);
      event_in = 1'b0;
      repeat (4) step();

      // Capture latency
      step();
      event_in = 1'b1;
      e = counter_value + 64'd2;
      step();
      event_in = 1'b0;
      check("lat_k_valid", 64'(ts_valid), 64'd0);
      step();
      check("lat_k1_valid", 64'(ts_valid), 64'd0);
      step();
      check("lat_k2_valid", 64'(ts_valid), 64'd1);
      check("lat_k2_data", ts_data, e);
      check("lat_k2_count", 64'(ts_count), 64'd1);
      step();
      check("lat_hold_count", 64'(ts_count), 64'd1);
      pop_expect("lat_pop", e);
      check("lat_empty", 64'(ts_valid), 64'd0);

      // Fill and overflow
      q.delete();
      for (int i = 0; i < 6; i++) begin
         fire(e, 1'b0, 1'b0);
         q.push_back(e);
         repeat (2) step();
      end
      check("fill_count", 64'(ts_count), 64'd4);
      check("fill_ovf", 64'(overflow), 64'd1);
      check("fill_drop", 64'(drop_count), 64'd2);
      for (int i = 0; i < 4; i++) pop_expect($sformatf("fill_pop%0d", i), q[i]);
      check("fill_empty_valid", 64'(ts_valid), 64'd0);
      check("fill_empty_data", ts_data, 64'd0);

      overflow_clear = 1'b1;
      step();
      overflow_clear = 1'b0;
      check("clr_ovf", 64'(overflow), 64'd0);
      check("clr_drop", 64'(drop_count), 64'd0);

      // Push and pop together while full
      q.delete();
      for (int i = 0; i < 4; i++) begin
         fire(e, 1'b0, 1'b0);
         q.push_back(e);
      end
      fire(e, 1'b1, 1'b0);
      check("pp_count", 64'(ts_count), 64'd4);
      check("pp_ovf", 64'(overflow), 64'd0);
      check("pp_drop", 64'(drop_count), 64'd0);
      pop_expect("pp_pop0", q[1]);
      pop_expect("pp_pop1", q[2]);
      pop_expect("pp_pop2", q[3]);
      pop_expect("pp_pop3", e);
      check("pp_empty", 64'(ts_valid), 64'd0);

      // Clear versus drop
      q.delete();
      for (int i = 0; i < 4; i++) begin
         fire(e, 1'b0, 1'b0);
         q.push_back(e);
      end
      fire(e, 1'b0, 1'b0);
      check("cd_drop1", 64'(drop_count), 64'd1);
      fire(e, 1'b0, 1'b1);
      check("cd_ovf", 64'(overflow), 64'd1);
      check("cd_drop", 64'(drop_count), 64'd1);
      overflow_clear = 1'b1;
      step();
      overflow_clear = 1'b0;
      check("cd_clr_ovf", 64'(overflow), 64'd0);
      check("cd_clr_drop", 64'(drop_count), 64'd0);
      for (int i = 0; i < 4; i++) pop_expect($sformatf("cd_pop%0d", i), q[i]);
      check("cd_empty", 64'(ts_valid), 64'd0);

      // Enable gating
      capture_enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         fire(e, 1'b0, 1'b0);
         step();
      end
      check("dis_count", 64'(ts_count), 64'd0);
      check("dis_drop", 64'(drop_count), 64'd0);
      event_in = 1'b1;
      repeat (5) step();
      capture_enable = 1'b1;
      repeat (5) step();
      check("en_high_count", 64'(ts_count), 64'd0);
      event_in = 1'b0;
      repeat (3) step();
      fire(e, 1'b0, 1'b0);
      check("en_cap_count", 64'(ts_count), 64'd1);
      check("en_cap_data", ts_data, e);
      fire(e, 1'b0, 1'b0);
      check("pre_rst_count", 64'(ts_count), 64'd2);

      // Asynchronous reset mid-cycle
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 64'(ts_valid), 64'd0);
      check("arst_count", 64'(ts_count), 64'd0);
      check("arst_data", ts_data, 64'd0);
      step();
      rst_n = 1'b1;
      repeat (3) step();
      check("post_rst_count", 64'(ts_count), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
